// File: rtl/jkff_bank_arbiter.sv
// jkff_bank_arbiter
//   Round-robin arbiter that shares one external bank of WIDTH JK flops
//   between two requesters. A granted command drives the bank's j/k for
//   exactly one cycle, waits SETTLE cycles, then returns the bank state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/ready     command handshake (ready combinational, IDLE only)
//   req{0,1}_op              00 hold, 01 set, 10 clear, 11 toggle
//   req{0,1}_mask            bits the op applies to
//   j, k                     bank J/K inputs (registered)
//   q                        bank Q outputs
//   rsp_valid/rsp_id/rsp_q   one-cycle response strobe, owner, sampled state
//   busy                     high whenever not IDLE
//   rsp_err                  (JKB_CHECK_EN only) bank result mismatched the op
//
// Optional feature macro: JKB_CHECK_EN
module jkff_bank_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_mask,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_mask,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic             busy
`ifdef JKB_CHECK_EN
    ,
    output logic             rsp_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             id_r;
    logic [3:0]       cnt;
    logic             grant0, grant1, accept, acc_id;
    logic [1:0]       acc_op;
    logic [WIDTH-1:0] acc_mask, j_nxt, k_nxt;

    always_comb begin
        // Tie goes to whoever did not win last; last_grant resets to 1 so req0 wins first.
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == ST_IDLE) && grant0;
        req1_ready = (state == ST_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        acc_id     = req1_ready;
        acc_op     = req1_ready ? req1_op   : req0_op;
        acc_mask   = req1_ready ? req1_mask : req0_mask;

        j_nxt = '0;
        k_nxt = '0;
        case (acc_op)
            2'b01:   k_nxt = acc_mask;                        // set
            2'b10:   j_nxt = acc_mask;                        // clear
            2'b11:   begin j_nxt = acc_mask; k_nxt = acc_mask; end // toggle
            default: ;                                        // hold
        endcase

        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = (SETTLE == 0) ? ST_RESP : ST_SETTLE;
            ST_SETTLE: if ({28'd0, cnt} + 32'd1 >= SETTLE) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The j/k registers double as the latched command: they are loaded from the
    // mapped op/mask on accept and cleared on every other edge, so they are
    // nonzero only during DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            cnt        <= '0;
            j          <= '0;
            k          <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id_r       <= acc_id;
                last_grant <= acc_id;
                j          <= j_nxt;
                k          <= k_nxt;
            end else begin
                j <= '0;
                k <= '0;
            end
            if (state == ST_SETTLE)
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rsp_id    = (state == ST_RESP) && id_r;
        rsp_q     = (state == ST_RESP) ? q : '0;
    end

`ifdef JKB_CHECK_EN
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r, q_pre, q_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= '0;
            mask_r <= '0;
            q_pre  <= '0;
        end else begin
            if (accept) begin
                op_r   <= acc_op;
                mask_r <= acc_mask;
            end
            // q during DRIVE is the state before the bank applies j/k.
            if (state == ST_DRIVE)
                q_pre <= q;
        end
    end

    always_comb begin
        case (op_r)
            2'b01:   q_exp = q_pre | mask_r;
            2'b10:   q_exp = q_pre & ~mask_r;
            2'b11:   q_exp = q_pre ^ mask_r;
            default: q_exp = q_pre;
        endcase
        rsp_err = (state == ST_RESP) && (q != q_exp);
    end
`endif

endmodule

// File: doc/jkff_bank_arbiter.md
Name: jkff_bank_arbiter

Overview:
- Shares one external bank of WIDTH JK flip-flops between two requesters (req0, req1).
- Arbitrates round-robin and accepts one command per transaction (valid/ready).
- Sequences the bank's j/k inputs for exactly one cycle, waits a settle interval, then returns the sampled bank state to the winning requester.
- Sits between software/FSM requesters and the flop bank; it is the only block allowed to drive the bank's j/k.

Parameters:
- WIDTH, 8, number of JK flops in the bank (1..32).
- SETTLE, 1, idle cycles between the drive cycle and q sampling (0..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  2  00 hold/readback, 01 set, 10 clear, 11 toggle.
- req0_mask  input  WIDTH  bits the op applies to.
- req1_valid, req1_ready, req1_op, req1_mask: same as requester 0, for requester 1.
- j  output  WIDTH  bank J inputs.
- k  output  WIDTH  bank K inputs.
- q  input  WIDTH  bank Q outputs. Bank reset value is all ones.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  1  requester that owns the response.
- rsp_q  output  WIDTH  bank state sampled after settle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous on clk when rst=1):
  - state=IDLE; j=k=0; rsp_valid=0; rsp_id=0; rsp_q=0; busy=0; last_grant=1.
  - Reset mid-transaction aborts the transaction with no response and j/k=0 on the next cycle.
- Bank encoding per bit {j,k}:
  - 00 hold, 10 clear (q->0), 01 set (q->1), 11 toggle.
  - Op mapping: set -> j=0,k=1; clear -> j=1,k=0; toggle -> j=1,k=1; hold -> 00.
  - Unmasked bits are always 00.
- FSM: IDLE -> DRIVE -> SETTLE (skipped when SETTLE=0) -> RESP -> IDLE.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one that is not last_grant, so req0 wins first after reset.
  - reqN_ready is combinational, high only in IDLE and only for the granted requester.
  - On accept, latch op/mask/id, update last_grant, go to DRIVE.
- DRIVE: j/k registered outputs carry the mapped pattern for exactly this one cycle; the bank updates on the closing edge.
- SETTLE: j=k=0; count SETTLE cycles, then go to RESP.
- RESP:
  - rsp_valid=1, rsp_id=latched id, rsp_q=q sampled this cycle; held stable only this cycle.
  - Next state IDLE. No acceptance occurs in RESP.
- Latency: accept at cycle T; j/k active at T+1; rsp_valid at T+2+SETTLE; next accept earliest at T+3+SETTLE.
- Boundary conditions:
  - mask=0 or op=hold runs the full sequence with j=k=0 (pure readback).
  - A requester that drops valid before being granted is not served.
  - valid held through busy is served once IDLE returns.
  - j and k are never nonzero outside DRIVE.

Optional Feature:
- Macro: JKB_CHECK_EN.
- When defined:
  - Adds output rsp_err (1 bit).
  - During DRIVE, capture q as q_pre. Compute expected: set bits ->1, clear bits ->0, toggle bits ->~q_pre, others q_pre.
  - In RESP, rsp_err=1 if rsp_q != expected. rsp_err is 0 outside RESP and in reset.
- When undefined: no rsp_err port and no compare logic.

Test Plan:
- Reset, bank at all ones; req0 op=10 mask=0x0F, SETTLE=1 -> ready at T; j=0x0F, k=0x00 at T+1 only; rsp_valid at T+3 with rsp_id=0, rsp_q=0xF0.
- Both requesters valid at once after reset (req0 toggle 0xFF, req1 set 0x01) -> req0 served first (rsp_q=0x00), then req1 (rsp_q=0x01, rsp_id=1); the next tie goes to req0.
- req1 op=00 mask=0xAA -> j=k=0 throughout; rsp_q equals the bank state; response latency is identical to other ops.
- SETTLE=0 -> rsp_valid at T+2; next ready at T+3.
- rst asserted during SETTLE -> no rsp_valid; j=k=0, busy=0, req0_ready possible the cycle after rst drops.
- JKB_CHECK_EN, bank model forced to ignore j/k bit 3 on a toggle of 0x08 -> rsp_err=1 in RESP; with a correct bank, rsp_err=0.
